// File: rtl/byte_data_memory_if.sv
// Request/response bus between a MIPS datapath and its byte-addressed data memory.
// The requester holds req and the request fields until it sees ready.
interface byte_data_memory_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              memWrite;
    logic [1:0]        accSize;
    logic              loadUnsigned;
    logic [ADDR_W-1:0] address;
    logic [31:0]       writeData;
    logic              ready;
    logic              rspValid;
    logic [31:0]       readData;
    logic              misaligned;

    modport master (
        output req, memWrite, accSize, loadUnsigned, address, writeData,
        input  ready, rspValid, readData, misaligned
    );

    modport slave (
        input  req, memWrite, accSize, loadUnsigned, address, writeData,
        output ready, rspValid, readData, misaligned
    );
endinterface

// File: rtl/byte_data_memory.sv
// Little-endian 32-bit data memory with byte/half/word access, sign/zero-extended loads,
// misalignment reporting and a configurable number of wait states per access.
module byte_data_memory #(
    parameter int length      = 256,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = $clog2(length) + 2
) (
    input logic               clk,
    input logic               reset_n,
    byte_data_memory_if.slave bus
);
    localparam int         IDX_W     = ADDR_W - 2;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [31:0]       mem [length];

    logic              wr_p0;
    logic [1:0]        sz_p0;
    logic              uns_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [31:0]       wdata_p0;

    logic              wr_c;
    logic [1:0]        sz_c;
    logic              uns_c;
    logic [ADDR_W-1:0] addr_c;
    logic [31:0]       wdata_c;
    logic [IDX_W-1:0]  idx_c;
    logic [31:0]       rd_word;
    logic [3:0]        be_c;
    logic [31:0]       wlane_c;
    logic              fault_c;
    logic              enter_resp;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            2'b10:   return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_enable(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data onto every lane it could land in.
    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic uns);
        logic [31:0]        shifted;
        logic signed [7:0]  sbyte;
        logic signed [15:0] shalf;
        shifted = word >> {lane, 3'b000};
        sbyte   = shifted[7:0];
        shalf   = shifted[15:0];
        case (sz)
            2'b00:   return uns ? {24'd0, shifted[7:0]}  : 32'(sbyte);
            2'b01:   return uns ? {16'd0, shifted[15:0]} : 32'(shalf);
            default: return word;
        endcase
    endfunction

    // With zero wait states the commit edge is also the acceptance edge, so use the live bus.
    always_comb begin
        wr_c    = wr_p0;
        sz_c    = sz_p0;
        uns_c   = uns_p0;
        addr_c  = addr_p0;
        wdata_c = wdata_p0;
        if (state == IDLE) begin
            wr_c    = bus.memWrite;
            sz_c    = bus.accSize;
            uns_c   = bus.loadUnsigned;
            addr_c  = bus.address;
            wdata_c = bus.writeData;
        end
    end

    assign idx_c      = addr_c[ADDR_W-1:2];
    assign rd_word    = mem[idx_c];
    assign be_c       = lane_enable(sz_c, addr_c[1:0]);
    assign wlane_c    = store_lanes(sz_c, wdata_c);
    assign fault_c    = is_misaligned(sz_c, addr_c[1:0]);
    assign enter_resp = ((state == IDLE) && bus.req && (WAIT_STATES == 0)) ||
                        ((state == WAIT) && (cnt == 4'd0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            bus.ready      <= 1'b1;
            bus.rspValid   <= 1'b0;
            bus.readData   <= 32'd0;
            bus.misaligned <= 1'b0;
        end else begin
            bus.rspValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        wr_p0     <= bus.memWrite;
                        sz_p0     <= bus.accSize;
                        uns_p0    <= bus.loadUnsigned;
                        addr_p0   <= bus.address;
                        wdata_p0  <= bus.writeData;
                        bus.ready <= 1'b0;
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            // Commit/capture stage: stores write their lanes, loads register the extended result.
            if (enter_resp) begin
                bus.rspValid   <= 1'b1;
                bus.misaligned <= fault_c;
                bus.readData   <= (wr_c || fault_c) ? 32'd0
                                  : load_extend(rd_word, sz_c, addr_c[1:0], uns_c);
                if (wr_c && !fault_c) begin
                    for (int k = 0; k < 4; k++) begin
                        if (be_c[k]) mem[idx_c][8*k +: 8] <= wlane_c[8*k +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_byte_data_memory.sv
// Bench for byte_data_memory: one instance with no wait states, one with three.
// Constant vector table, randomized accesses against a byte-array model, and reset sequences.
module tb_byte_data_memory;
    localparam int LEN = 256;
    localparam int AW  = 10;
    localparam int NV  = 24;

    logic clk = 1'b0;
    logic rst0_n;
    logic rst3_n;
    always #5 clk = ~clk;

    byte_data_memory_if #(.ADDR_W(AW)) b0 ();
    byte_data_memory_if #(.ADDR_W(AW)) b3 ();

    byte_data_memory #(.length(LEN), .WAIT_STATES(0)) u0 (.clk(clk), .reset_n(rst0_n), .bus(b0.slave));
    byte_data_memory #(.length(LEN), .WAIT_STATES(3)) u3 (.clk(clk), .reset_n(rst3_n), .bus(b3.slave));

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] mm [2][LEN*4];

    typedef struct {
        logic          wr;
        logic [1:0]    sz;
        logic          uns;
        logic [AW-1:0] a;
        logic [31:0]   wd;
        logic [31:0]   exp_rd;
        logic          exp_mis;
    } vec_t;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: memory as a flat byte array, extension by plain arithmetic.
    function automatic void model_access(input int d, input logic wr, input logic [1:0] sz,
                                         input logic uns, input int addr, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic mis);
        int     nbytes;
        longint val;
        nbytes = 1 << sz;
        mis    = (sz == 2'b11) || (addr % nbytes != 0);
        rd     = 32'd0;
        if (mis) return;
        if (wr) begin
            for (int i = 0; i < nbytes; i++) mm[d][addr + i] = wd[8*i +: 8];
        end else begin
            val = 0;
            for (int i = 0; i < nbytes; i++) val += longint'(mm[d][addr + i]) << (8 * i);
            if (!uns && nbytes < 4 && val >= (longint'(1) << (8 * nbytes - 1)))
                val -= longint'(1) << (8 * nbytes);
            rd = 32'(val);
        end
    endfunction

    function automatic logic get_ready(input int d);
        return (d == 0) ? b0.ready : b3.ready;
    endfunction
    function automatic logic get_rsp(input int d);
        return (d == 0) ? b0.rspValid : b3.rspValid;
    endfunction
    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? b0.readData : b3.readData;
    endfunction
    function automatic logic get_mis(input int d);
        return (d == 0) ? b0.misaligned : b3.misaligned;
    endfunction

    task automatic drive(input int d, input logic rq, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [AW-1:0] a, input logic [31:0] wd);
        if (d == 0) begin
            b0.req = rq; b0.memWrite = wr; b0.accSize = sz;
            b0.loadUnsigned = uns; b0.address = a; b0.writeData = wd;
        end else begin
            b3.req = rq; b3.memWrite = wr; b3.accSize = sz;
            b3.loadUnsigned = uns; b3.address = a; b3.writeData = wd;
        end
    endtask

    // One complete access; called #1 after a rising edge.
    task automatic access(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [AW-1:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_mis, input string name);
        int ws, n, lowc;
        ws = (d == 0) ? 0 : 3;
        drive(d, 1'b1, wr, sz, uns, a, wd);
        n = 0;
        while (!get_ready(d) && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 2'b00, 1'b0, '0, 32'd0);
        n = 1;
        lowc = 0;
        while (!get_rsp(d) && n < 40) begin
            if (!get_ready(d)) lowc++;
            @(posedge clk); #1;
            n++;
        end
        if (!get_rsp(d)) begin
            chk({name, "_rsp_timeout"}, 32'(get_rsp(d)), 32'd1);
            return;
        end
        if (!get_ready(d)) lowc++;
        chk({name, "_latency"}, 32'(n), 32'(ws + 1));
        chk({name, "_rd"}, get_rd(d), exp_rd);
        chk({name, "_mis"}, 32'(get_mis(d)), 32'(exp_mis));
        @(posedge clk); #1;
        chk({name, "_strobe_one_cycle"}, 32'(get_rsp(d)), 32'd0);
        chk({name, "_ready_low_cycles"}, 32'(lowc), 32'(ws + 1));
        chk({name, "_ready_back"}, 32'(get_ready(d)), 32'd1);
        chk({name, "_rd_held"}, get_rd(d), exp_rd);
    endtask

    initial begin
        logic [31:0] erd;
        logic        emis;
        logic        wr, uns;
        logic [1:0]  sz;
        logic [AW-1:0] a;
        logic [31:0] wd;
        int          r, n;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 1'b0, 10'h013, 32'h12345680, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 10'h013, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 10'h013, 32'h0,        32'h00000080, 1'b0};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,        32'h80ADBEEF, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 10'h011, 32'h00001234, 32'h00000000, 1'b1};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,        32'h80ADBEEF, 1'b0};
        vecs[8]  = '{1'b0, 2'b11, 1'b0, 10'h010, 32'h0,        32'h00000000, 1'b1};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, 10'h020, 32'h80017FFF, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 10'h022, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[11] = '{1'b0, 2'b01, 1'b1, 10'h022, 32'h0,        32'h00008001, 1'b0};
        vecs[12] = '{1'b0, 2'b01, 1'b0, 10'h020, 32'h0,        32'h00007FFF, 1'b0};
        vecs[13] = '{1'b0, 2'b10, 1'b0, 10'h021, 32'h0,        32'h00000000, 1'b1};
        vecs[14] = '{1'b0, 2'b00, 1'b0, 10'h021, 32'h0,        32'h0000007F, 1'b0};
        vecs[15] = '{1'b0, 2'b00, 1'b0, 10'h020, 32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[16] = '{1'b1, 2'b01, 1'b0, 10'h022, 32'h5555ABCD, 32'h00000000, 1'b0};
        vecs[17] = '{1'b0, 2'b10, 1'b0, 10'h020, 32'h0,        32'hABCD7FFF, 1'b0};
        vecs[18] = '{1'b0, 2'b00, 1'b1, 10'h023, 32'h0,        32'h000000AB, 1'b0};
        vecs[19] = '{1'b1, 2'b11, 1'b0, 10'h020, 32'h0,        32'h00000000, 1'b1};
        vecs[20] = '{1'b0, 2'b10, 1'b0, 10'h020, 32'h0,        32'hABCD7FFF, 1'b0};
        vecs[21] = '{1'b0, 2'b10, 1'b1, 10'h020, 32'h0,        32'hABCD7FFF, 1'b0};
        vecs[22] = '{1'b1, 2'b00, 1'b0, 10'h020, 32'h000000EE, 32'h00000000, 1'b0};
        vecs[23] = '{1'b0, 2'b01, 1'b0, 10'h020, 32'h0,        32'h00007FEE, 1'b0};

        rst0_n = 1'b0;
        rst3_n = 1'b0;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, '0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, '0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ready_%0d", d), 32'(get_ready(d)), 32'd1);
            chk($sformatf("reset_rsp_%0d", d), 32'(get_rsp(d)), 32'd0);
            chk($sformatf("reset_rd_%0d", d), get_rd(d), 32'd0);
            chk($sformatf("reset_mis_%0d", d), 32'(get_mis(d)), 32'd0);
        end
        rst0_n = 1'b1;
        rst3_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++)
            access(0, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd,
                   vecs[i].exp_rd, vecs[i].exp_mis, $sformatf("vec%0d", i));

        // Known contents for the random window 0x40..0x7F on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int w = 16; w < 32; w++) begin
                wd = $urandom;
                model_access(d, 1'b1, 2'b10, 1'b0, w * 4, wd, erd, emis);
                access(d, 1'b1, 2'b10, 1'b0, AW'(w * 4), wd, erd, emis, $sformatf("init%0d_%0d", d, w));
            end
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                wr  = 1'($urandom_range(0, 1));
                uns = 1'($urandom_range(0, 1));
                r   = $urandom_range(0, 9);
                sz  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
                a   = AW'($urandom_range(64, 127));
                wd  = $urandom;
                model_access(d, wr, sz, uns, int'(a), wd, erd, emis);
                access(d, wr, sz, uns, a, wd, erd, emis, $sformatf("rnd%0d_%0d", d, i));
            end
        end

        // Held request on the wait-state instance: one access every 5 cycles, none lost or repeated.
        model_access(1, 1'b0, 2'b10, 1'b0, 'h40, 32'd0, erd, emis);
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 10'h040, 32'd0);
        for (int c = 0; c < 15; c++) begin
            chk($sformatf("b2b_ready_c%0d", c), 32'(get_ready(1)), 32'(c % 5 == 0));
            chk($sformatf("b2b_rsp_c%0d", c), 32'(get_rsp(1)), 32'(c % 5 == 4));
            if (c % 5 == 4) chk($sformatf("b2b_rd_c%0d", c), get_rd(1), erd);
            @(posedge clk); #1;
        end
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, '0, 32'd0);
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("b2b_no_extra_c%0d", c), 32'(get_rsp(1)), 32'd0);
            @(posedge clk); #1;
        end

        // Reset during WAIT discards an uncommitted store.
        access(1, 1'b1, 2'b10, 1'b0, 10'h020, 32'hCAFEF00D, 32'd0, 1'b0, "rst_pre_sw");
        access(1, 1'b0, 2'b10, 1'b0, 10'h020, 32'd0, 32'hCAFEF00D, 1'b0, "rst_pre_lw");
        drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 10'h020, 32'h11111111);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, '0, 32'd0);
        @(posedge clk); #1;
        chk("mid_wait_ready", 32'(get_ready(1)), 32'd0);
        rst3_n = 1'b0;
        #1;
        chk("rst_wait_ready", 32'(get_ready(1)), 32'd1);
        chk("rst_wait_rsp", 32'(get_rsp(1)), 32'd0);
        chk("rst_wait_rd", get_rd(1), 32'd0);
        chk("rst_wait_mis", 32'(get_mis(1)), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst3_n = 1'b1;
        access(1, 1'b0, 2'b10, 1'b0, 10'h020, 32'd0, 32'hCAFEF00D, 1'b0, "rst_discard_lw");

        // Reset during RESP keeps the already committed store.
        drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 10'h024, 32'h22222222);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, '0, 32'd0);
        n = 0;
        while (!get_rsp(1) && n < 20) begin @(posedge clk); #1; n++; end
        chk("commit_rsp_seen", 32'(get_rsp(1)), 32'd1);
        rst3_n = 1'b0;
        #1;
        chk("rst_resp_rsp", 32'(get_rsp(1)), 32'd0);
        chk("rst_resp_ready", 32'(get_ready(1)), 32'd1);
        @(posedge clk); #1;
        rst3_n = 1'b1;
        access(1, 1'b0, 2'b10, 1'b0, 10'h024, 32'd0, 32'h22222222, 1'b0, "rst_commit_lw");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
